// File: rtl/disp_pkg.sv
// Display definitions shared by the LM75 temperature path and scan_led:
// digit codes, digit field positions, converter FSM states.
package disp_pkg;

    localparam logic [3:0] BLANK_CODE_DEF = 4'hF;
    localparam logic [3:0] MINUS_CODE_DEF = 4'hA;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned SIGN_LSB  = 16;
    localparam int unsigned HUND_LSB  = 12;
    localparam int unsigned TENS_LSB  = 8;
    localparam int unsigned UNIT_LSB  = 4;
    localparam int unsigned TENTH_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_SHIFT,
        ST_LOAD
    } conv_state_t;

    // Eighths of a degree to tenths, truncated (frac * 10 / 8).
    function automatic logic [3:0] tenths_digit(input logic [2:0] frac);
        tenths_digit = 4'd0;
        case (frac)
            3'd0: tenths_digit = 4'd0;
            3'd1: tenths_digit = 4'd1;
            3'd2: tenths_digit = 4'd2;
            3'd3: tenths_digit = 4'd3;
            3'd4: tenths_digit = 4'd5;
            3'd5: tenths_digit = 4'd6;
            3'd6: tenths_digit = 4'd7;
            3'd7: tenths_digit = 4'd8;
            default: tenths_digit = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/bin8_to_bcd3.sv
// Sequential double-dabble: 8-bit binary to three BCD digits, one bit per step.
module bin8_to_bcd3 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [7:0]  i_bin,
    output logic [11:0] o_bcd,
    output logic        o_last
);

    logic [19:0] r_sr;
    logic [2:0]  r_cnt;
    logic [19:0] w_adj;

    always_comb begin
        w_adj = r_sr;
        for (int unsigned i = 0; i < 3; i++) begin
            if (w_adj[8 + 4*i +: 4] >= 4'd5) begin
                w_adj[8 + 4*i +: 4] = w_adj[8 + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sr  <= {12'd0, i_bin};
            r_cnt <= '0;
        end else if (i_step) begin
            r_sr  <= w_adj << 1;
            r_cnt <= r_cnt + 3'd1;
        end
    end

    assign o_bcd  = r_sr[19:8];
    assign o_last = i_step && (r_cnt == 3'd7);

endmodule

// File: rtl/temp_to_bcd.sv
// LM75 11-bit reading (0.125 C/LSB) to the five-digit sign/hundreds/tens/
// units/tenths word driven into scan_led.hms_in.
module temp_to_bcd
    import disp_pkg::*;
#(
    parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF,
    parameter logic [3:0] MINUS_CODE = MINUS_CODE_DEF,
    parameter bit         LZ_BLANK   = 1'b1
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [10:0] temp_raw,
    input  logic        temp_valid,
    output logic [19:0] hms_out,
    output logic        busy,
    output logic        done
);

    conv_state_t r_state;
    conv_state_t w_next;

    logic [10:0] r_raw;
    logic [19:0] r_hms;
    logic        r_done;

    logic        w_load;
    logic        w_step;
    logic        w_cvt_last;
    logic [10:0] w_mag;
    logic [11:0] w_bcd;
    logic [3:0]  w_hund;
    logic [3:0]  w_tens;
    logic [3:0]  w_unit;
    logic [19:0] w_hms_new;

    // Unsigned 11-bit magnitude: 11'h400 negates to 1024 without overflow.
    assign w_mag  = r_raw[10] ? (~r_raw + 11'd1) : r_raw;
    assign w_hund = w_bcd[11:8];
    assign w_tens = w_bcd[7:4];
    assign w_unit = w_bcd[3:0];

    bin8_to_bcd3 u_bcd (
        .i_clk  (sys_clk),
        .i_rst  (rst),
        .i_load (w_load),
        .i_step (w_step),
        .i_bin  (w_mag[10:3]),
        .o_bcd  (w_bcd),
        .o_last (w_cvt_last)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (temp_valid) begin
                    w_next = ST_PREP;
                end
            end
            ST_PREP: begin
                w_load = 1'b1;
                w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_step = 1'b1;
                if (w_cvt_last) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Tens blanks only when hundreds is also zero, so 105.0 keeps its 0.
    always_comb begin
        w_hms_new = '0;
        w_hms_new[SIGN_LSB +: DIGIT_W]  = r_raw[10] ? MINUS_CODE : BLANK_CODE;
        w_hms_new[HUND_LSB +: DIGIT_W]  = (LZ_BLANK && (w_hund == 4'd0)) ? BLANK_CODE : w_hund;
        w_hms_new[TENS_LSB +: DIGIT_W]  = (LZ_BLANK && (w_hund == 4'd0) && (w_tens == 4'd0))
                                          ? BLANK_CODE : w_tens;
        w_hms_new[UNIT_LSB +: DIGIT_W]  = w_unit;
        w_hms_new[TENTH_LSB +: DIGIT_W] = tenths_digit(w_mag[2:0]);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_raw  <= '0;
            r_hms  <= {5{BLANK_CODE}};
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == ST_IDLE) && temp_valid) begin
                r_raw <= temp_raw;
            end
            if (r_state == ST_LOAD) begin
                r_hms  <= w_hms_new;
                r_done <= 1'b1;
            end
        end
    end

    assign hms_out = r_hms;
    assign done    = r_done;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_temp_to_bcd.sv
// Scoreboard bench for temp_to_bcd: two instances (leading-zero blanking on/off)
// checked against an arithmetic reference model and a latency-counter acceptance model.
module tb_temp_to_bcd;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] temp_raw = '0;
    logic        temp_valid = 1'b0;
    logic [19:0] hms_out;
    logic        busy;
    logic        done;
    logic [19:0] hms_lz0;
    logic        busy_lz0;
    logic        done_lz0;

    int checks = 0;
    int errors = 0;

    logic [19:0] exp_q[$];
    logic [19:0] exp_q0[$];
    logic [19:0] m_hold  = 20'hFFFFF;
    logic [19:0] m_hold0 = 20'hFFFFF;
    int          m_cnt = 0;
    bit          m_done_exp = 1'b0;

    temp_to_bcd dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .temp_raw   (temp_raw),
        .temp_valid (temp_valid),
        .hms_out    (hms_out),
        .busy       (busy),
        .done       (done)
    );

    temp_to_bcd #(.LZ_BLANK(1'b0)) dut_lz0 (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .temp_raw   (temp_raw),
        .temp_valid (temp_valid),
        .hms_out    (hms_lz0),
        .busy       (busy_lz0),
        .done       (done_lz0)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [19:0] ref_disp(input logic [10:0] raw, input bit lz);
        int v, mag, ip, t10, h, t, u;
        logic [3:0] ds, dh, dt;
        v   = int'($signed(raw));
        mag = (v < 0) ? -v : v;
        ip  = mag / 8;
        t10 = ((mag % 8) * 10) / 8;
        h   = ip / 100;
        t   = (ip / 10) % 10;
        u   = ip % 10;
        ds  = (v < 0) ? 4'hA : 4'hF;
        dh  = (lz && h == 0) ? 4'hF : 4'(h);
        dt  = (lz && h == 0 && t == 0) ? 4'hF : 4'(t);
        return {ds, dh, dt, 4'(u), 4'(t10)};
    endfunction

    task automatic check20(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Acceptance model: a strobe is taken only when no conversion is in flight,
    // and the result appears 10 edges later.
    always @(posedge sys_clk) begin
        m_done_exp = 1'b0;
        if (rst) begin
            m_cnt = 0;
            exp_q.delete();
            exp_q0.delete();
            m_hold  = 20'hFFFFF;
            m_hold0 = 20'hFFFFF;
        end else if (m_cnt == 0) begin
            if (temp_valid) begin
                m_cnt = 10;
                exp_q.push_back(ref_disp(temp_raw, 1'b1));
                exp_q0.push_back(ref_disp(temp_raw, 1'b0));
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) m_done_exp = 1'b1;
        end
    end

    always @(negedge sys_clk) begin
        chk1("busy", busy, m_cnt != 0);
        chk1("done", done, m_done_exp);
        chk1("busy_lz0", busy_lz0, m_cnt != 0);
        chk1("done_lz0", done_lz0, m_done_exp);
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: hms_out=%h with empty scoreboard", hms_out);
            end else begin
                m_hold = exp_q.pop_front();
            end
        end
        if (done_lz0 === 1'b1) begin
            if (exp_q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected_lz0: hms_out=%h with empty scoreboard", hms_lz0);
            end else begin
                m_hold0 = exp_q0.pop_front();
            end
        end
        check20("hms_out", hms_out, m_hold);
        check20("hms_out_lz0", hms_lz0, m_hold0);
    end

    task automatic strobe(input logic [10:0] v);
        temp_valid = 1'b1;
        temp_raw   = v;
        @(negedge sys_clk);
        temp_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = -1;
        for (int c = 1; c <= max; c++) begin
            @(negedge sys_clk);
            if (done === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic dir(input string name, input logic [10:0] raw,
                       input logic [19:0] e1, input logic [19:0] e0);
        int n;
        strobe(raw);
        wait_done(20, n);
        check_int({name, "_latency"}, n, 10);
        check20({name, "_hms"}, hms_out, e1);
        check20({name, "_hms_lz0"}, hms_lz0, e0);
    endtask

    initial begin
        int n;
        int ndone;
        rst        = 1'b1;
        temp_valid = 1'b0;
        temp_raw   = '0;
        repeat (2) @(negedge sys_clk);
        check20("reset_hms", hms_out, 20'hFFFFF);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        rst = 1'b0;

        // Back-to-back: each strobe lands in the cycle right after done.
        dir("p25_0",    11'h0C8, 20'hFF250, 20'hF0250);
        dir("p125_125", 11'h3E9, 20'hF1251, 20'hF1251);
        dir("zero",     11'h000, 20'hFFF00, 20'hF0000);
        dir("m25_5",    11'h734, 20'hAF255, 20'hA0255);
        dir("m0_125",   11'h7FF, 20'hAFF01, 20'hA0001);
        dir("m128",     11'h400, 20'hA1280, 20'hA1280);

        strobe(11'h0C8);
        repeat (3) @(negedge sys_clk);
        strobe(11'h3E9);
        ndone = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (done === 1'b1) ndone++;
        end
        check_int("drop_done_count", ndone, 1);
        check20("drop_hms", hms_out, 20'hFF250);

        strobe(11'h3E9);
        repeat (3) @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        check20("abort_hms", hms_out, 20'hFFFFF);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        wait_done(15, n);
        check_int("abort_no_done", n, -1);

        for (int i = 0; i < 2048; i++) begin
            strobe(11'(i));
            repeat (10) @(negedge sys_clk);
        end

        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            temp_valid = ($urandom_range(0, 2) == 0);
            temp_raw   = 11'($urandom);
            @(negedge sys_clk);
        end
        rst        = 1'b0;
        temp_valid = 1'b0;
        repeat (15) @(negedge sys_clk);
        check_int("scoreboard_empty", exp_q.size(), 0);
        check_int("scoreboard_empty_lz0", exp_q0.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/temp_to_bcd.md
# temp_to_bcd

Converts the signed 11-bit LM75 temperature reading (0.125 °C per LSB) into the five-digit display word consumed by `scan_led` on its `hms_in[19:0]`. Digit layout is `[19:16]` sign, `[15:12]` hundreds, `[11:8]` tens, `[7:4]` units and `[3:0]` tenths. `scan_led` lights the decimal point on the `[7:4]` digit. The block sits between the LM75 I2C reader and `scan_led`. It runs a multi-cycle double-dabble conversion and holds its output stable between samples.

## Interface
- `BLANK_CODE`, default 4'hF: digit code that the downstream decoder renders as an unlit digit.
- `MINUS_CODE`, default 4'hA: digit code that the downstream decoder renders as '-'.
- `LZ_BLANK`, default 1: 1 blanks leading-zero hundreds/tens; 0 shows them as 0.
- `sys_clk` input 1: single system clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `temp_raw` input 11: LM75 temperature register bits [15:5], two's complement, 0.125 °C/LSB.
- `temp_valid` input 1: one-cycle strobe; `temp_raw` is valid in the same cycle.
- `hms_out` output 20: five packed 4-bit digits; connects to `scan_led.hms_in`.
- `busy` output 1: conversion in progress; new strobes are ignored while high.
- `done` output 1: one-cycle pulse in the cycle `hms_out` first shows the new value.

## Operation
- The FSM has four states: IDLE, PREP, SHIFT, LOAD.
- IDLE: when `temp_valid`=1, latch `temp_raw` and go to PREP. When `temp_valid`=0, stay in IDLE.
- PREP: compute the sign and the 11-bit magnitude.
  - The magnitude is the two's-complement negation when bit 10 is set.
  - 11'h400 gives magnitude 1024; this must not overflow.
  - Split the magnitude into int = mag[10:3] (0..128) and frac = mag[2:0].
  - Load the shift register and clear the bit counter. Go to SHIFT.
- SHIFT: perform 8 double-dabble iterations, one per cycle.
  - Before each shift, add 3 to any BCD nibble ≥ 5.
  - Exit to LOAD when the counter reaches 7.
- LOAD: assemble and register `hms_out`, pulse `done`, return to IDLE.
- Tenths digit (truncation of frac×10/8): frac 0..7 maps to 0,1,2,3,5,6,7,8.
- Sign digit: `MINUS_CODE` if the raw reading is negative, otherwise `BLANK_CODE`.
  - -0.125 (11'h7FF) is negative and shows minus.
- Leading zeros, when `LZ_BLANK`=1:
  - hundreds=0 → `BLANK_CODE`.
  - hundreds=0 and tens=0 → tens also `BLANK_CODE`.
  - Units and tenths are always numeric.
- `hms_out` changes only in LOAD; it holds its value at all other times.
- `temp_valid` while `busy`=1 is dropped, with no queueing.
- `busy`=1 in PREP, SHIFT and LOAD.

## Timing
- Reset values: `hms_out`=20'hFFFFF (all blank), `busy`=0, `done`=0, state IDLE, latched operand 0.
- Edge E0 samples `temp_valid`=1 in IDLE. After E0, `busy`=1.
- E1: PREP. E2..E9: SHIFT. E10: LOAD.
- After E10: new `hms_out` is visible, `done`=1 for one cycle, `busy`=0.
- Latency is 10 cycles from the accepting edge to output. Accept-to-accept throughput is 11 cycles.
- A strobe in the first cycle after LOAD (`busy`=0) is accepted.
- A strobe coincident with the LOAD edge is dropped.
- `rst` asserted in any state: the next edge forces the reset values and aborts the conversion. `hms_out` returns to all blank and `done` does not pulse.
- `rst` has priority over `temp_valid` in the same cycle.

## Structure
- Shared package `disp_pkg`:
  - `BLANK_CODE` and `MINUS_CODE` defaults.
  - FSM state encodings.
  - Digit field indices (SIGN=19:16, HUND=15:12, TENS=11:8, UNIT=7:4, TENTH=3:0).
  - `scan_led` also uses these.
- Sub-module `bin8_to_bcd3`: sequential double-dabble for an 8-bit input and 12-bit BCD output, with load/step/done. `temp_to_bcd` instantiates it and adds sign, tenths and blanking.

## Test plan
- Reset: hold `rst`=1 for 2 cycles → `hms_out`=20'hFFFFF, `busy`=0, `done`=0. Assert `rst` mid-SHIFT → same values next cycle, no `done`.
- `temp_raw`=11'h0C8 (+25.0) → 10 cycles later `hms_out`=20'hFF250, `done` high 1 cycle; `busy` high for cycles 1..10.
- `temp_raw`=11'h3E9 (+125.125) → 20'hF1251. `temp_raw`=11'h000 → 20'hFFF00. With `LZ_BLANK`=0, 11'h000 → 20'hF0000.
- `temp_raw`=11'h734 (-25.5) → 20'hAF255. 11'h7FF (-0.125) → 20'hAFF01. 11'h400 (-128.0) → 20'hA1280.
- Send a strobe with 11'h0C8, then a strobe with 11'h3E9 four cycles later → the second is ignored: one `done`, `hms_out`=20'hFF250. A strobe one cycle after `done` is accepted.
- Sweep all 2048 `temp_raw` codes back-to-back → every `hms_out` matches a reference model, and `hms_out` is unchanged between `done` pulses.
